// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver (LSB first, idle-high line). Decoded bytes land
//            in a one-entry holding register with a valid/ready handshake;
//            framing errors and overruns are reported as one-cycle pulses.
// Ports    : clk        - system clock, rising edge
//            resetn     - asynchronous, active-low reset
//            rx         - serial input, asynchronous to clk, idle high
//            rx_data    - received byte, valid while rx_valid = 1
//            rx_valid   - holding register full
//            rx_ready   - consumer accepts rx_data on an edge with rx_valid = 1
//            frame_err  - one-cycle pulse: stop bit sampled low
//            overrun    - one-cycle pulse: byte completed while holding full
//            busy       - receiver is inside a frame (FSM not idle)
// Params   : CLKS_PER_BIT - clock cycles per bit period, even and >= 4
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  // Mid-point of the start bit: sampling here centres all later samples.
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } t_state;

  t_state             r_state;
  logic               r_s1;
  logic               r_s2;
  logic               r_s2_d;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_overrun;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_s2_d      <= 1'b1;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_s1        <= rx;
      r_s2        <= r_s1;
      r_s2_d      <= r_s2;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumption; a load in STOP below overrides this on the same edge.
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Needs a genuine high-to-low edge, so a held-low break never retriggers.
          if (r_s2_d && !r_s2) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            r_cnt <= '0;
            if (!r_s2) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              // Line went back high before mid-bit: glitch, not a start bit.
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_s2, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (r_s2) begin
              if (!r_valid || rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are driven bit by bit;
//            a frame-level reference model schedules the stop-sample outcome
//            and the busy window of every frame from the bit timing, then the
//            holding register / pulses / busy are compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int C = 4;
  localparam int H = C / 2;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] d;
    logic       stopb;
  } t_ev;

  typedef struct {
    int from;
    int to;
  } t_win;

  t_ev  ev_q[$];
  t_win win_q[$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_n   = 0;
  int         fe_cnt   = 0;
  int         ovr_cnt  = 0;
  logic       m_valid  = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic       m_fe     = 1'b0;
  logic       m_ovr    = 1'b0;
  logic       m_busy   = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference model: the outcome of each frame is decided at its scheduled
  // stop-sample edge; consumption follows the valid/ready rule.
  always @(posedge clk) begin : p_model
    t_ev  ev;
    logic pre;
    logic ld;
    edge_n++;
    if (resetn) begin
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      pre   = m_valid;
      ld    = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].at == edge_n) begin
        ev = ev_q.pop_front();
        if (ev.stopb) begin
          if (!pre || rx_ready) begin
            m_data  = ev.d;
            m_valid = 1'b1;
            ld      = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_fe = 1'b1;
        end
      end
      if (!ld && pre && rx_ready) m_valid = 1'b0;
      while (win_q.size() > 0 && win_q[0].to < edge_n) win_q.delete(0);
      m_busy = (win_q.size() > 0 && win_q[0].from <= edge_n);
    end
  end

  always @(posedge clk) begin
    #2;
    if (resetn) begin
      check("rx_valid", 32'(rx_valid), 32'(m_valid));
      check("rx_data", 32'(rx_data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_fe));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(m_busy));
      if (frame_err) fe_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rand_ready) rx_ready = ($urandom_range(0, 2) == 0);
  end

  // All drivers are entered at a negedge; the next posedge is edge_n + 1.
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    int   e0;
    t_ev  ev;
    t_win w;
    e0       = edge_n + 1;
    ev.at    = e0 + 2 + H + 9 * C;
    ev.d     = d;
    ev.stopb = stopb;
    ev_q.push_back(ev);
    w.from = e0 + 2;
    w.to   = e0 + 1 + H + 9 * C;
    win_q.push_back(w);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
    drive(stopb, C);
  endtask

  task automatic glitch();
    t_win w;
    w.from = edge_n + 3;
    w.to   = edge_n + 2 + H;
    win_q.push_back(w);
    drive(1'b0, 1);
    drive(1'b1, C);
  endtask

  task automatic pulse_ready_at(input int t);
    while (edge_n < t - 1) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int e0;
    int fe0;
    int ov0;
    t_win w;
    resetn   = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    drive(1'b1, 4);

    // Single byte with the consumer stalled
    fe0 = fe_cnt; ov0 = ovr_cnt;
    send_frame(8'h55, 1'b1);
    drive(1'b1, C);
    check("single_valid", 32'(rx_valid), 32'd1);
    check("single_data", 32'(rx_data), 32'h55);
    check("single_pulses", 32'(fe_cnt - fe0 + ovr_cnt - ov0), 32'd0);
    consume();
    check("consumed", 32'(rx_valid), 32'd0);

    // Start glitch followed by a good frame
    glitch();
    check("glitch_novalid", 32'(rx_valid), 32'd0);
    send_frame(8'hA3, 1'b1);
    drive(1'b1, C);
    check("glitch_next", 32'(rx_data), 32'hA3);
    consume();

    // Framing error with the line then held low
    fe0 = fe_cnt;
    send_frame(8'h0F, 1'b0);
    drive(1'b0, 20);
    check("ferr_count", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_novalid", 32'(rx_valid), 32'd0);
    check("ferr_nobusy", 32'(busy), 32'd0);
    drive(1'b1, C);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, C);
    check("ferr_next", 32'(rx_data), 32'h3C);
    consume();

    // Overrun on back-to-back frames
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, C);
    check("ovr_count", 32'(ovr_cnt - ov0), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);

    // Consume exactly on the load edge
    ov0 = ovr_cnt;
    e0  = edge_n + 1;
    fork
      send_frame(8'h22, 1'b1);
      pulse_ready_at(e0 + 2 + H + 9 * C);
    join
    drive(1'b1, C);
    check("col_ovr", 32'(ovr_cnt - ov0), 32'd0);
    check("col_valid", 32'(rx_valid), 32'd1);
    check("col_data", 32'(rx_data), 32'h22);

    // Reset during data bit 4 of 0xFF
    e0     = edge_n + 1;
    w.from = e0 + 2;
    w.to   = e0 + 1 + H + 9 * C;
    win_q.push_back(w);
    drive(1'b0, C);
    drive(1'b1, 4 * C + 2);
    resetn = 1'b0;
    ev_q.delete();
    win_q.delete();
    m_valid = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 2 * C);
    send_frame(8'h81, 1'b1);
    drive(1'b1, C);
    check("post_rst_data", 32'(rx_data), 32'h81);
    check("post_rst_valid", 32'(rx_valid), 32'd1);

    // Randomised traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        glitch();
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0);
        drive(1'b1, C);
      end else begin
        send_frame(8'($urandom), 1'b1);
      end
      drive(1'b1, $urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    rx_ready   = 1'b0;
    drive(1'b1, 3 * C);
    check("end_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
